// File: rtl/register_n.sv
// Parametrised datapath register: clear, load, inc/dec, shift/rotate/arith-shift
// with registered carry/borrow and shift-out status. Define REGISTER_N_SAT_EN for saturating inc/dec.
module register_n #(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cl,
  input  logic             ld,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             ir,
  input  logic             sl,
  input  logic             il,
  input  logic             rot,
  input  logic             asr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             co,
  output logic             so
);

  logic all_ones;
  logic all_zero;
  logic sr_fill;
  logic sl_fill;

  assign all_ones = &out;
  assign all_zero = ~|out;
  assign zero     = all_zero;

  // rotate wins over arithmetic fill, which wins over the serial input
  assign sr_fill = rot ? out[0] : (asr ? out[WIDTH-1] : ir);
  assign sl_fill = rot ? out[WIDTH-1] : il;

  // Status bits default to 0 so they pulse only for the edge that produced them.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= RESET_VALUE;
      co  <= 1'b0;
      so  <= 1'b0;
    end else begin
      co <= 1'b0;
      so <= 1'b0;
      if (cl) begin
        out <= '0;
      end else if (ld) begin
        out <= in;
      end else if (inc) begin
        co <= all_ones;
`ifdef REGISTER_N_SAT_EN
        if (!all_ones) out <= out + 1'b1;
`else
        out <= out + 1'b1;
`endif
      end else if (dec) begin
        co <= all_zero;
`ifdef REGISTER_N_SAT_EN
        if (!all_zero) out <= out - 1'b1;
`else
        out <= out - 1'b1;
`endif
      end else if (sr) begin
        so  <= out[0];
        out <= {sr_fill, out[WIDTH-1:1]};
      end else if (sl) begin
        so  <= out[WIDTH-1];
        out <= {out[WIDTH-2:0], sl_fill};
      end
    end
  end

endmodule
